// File: rtl/wb_master_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the two-master Wishbone arbiter:
//   - default address/data widths of the system bus (also used by the UART
//     debug bridge and the CPU bus interface)
//   - arbiter FSM state encoding
//   - master index constants
// No ports (package).
// ---------------------------------------------------------------------------
package wb_arb_pkg;

  localparam int WB_ADDR_W = 24;
  localparam int WB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DBG = 1'b1;

endpackage : wb_arb_pkg

// File: rtl/wb_master_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_master_arbiter_if
// One Wishbone link (classic single-cycle handshake, no err/rty/tags).
// Signals:
//   cyc, stb, we, addr, dat_w : master -> slave
//   ack, dat_r                : slave  -> master
// Modports:
//   master : the side that issues cycles
//   slave  : the side that answers cycles
// ---------------------------------------------------------------------------
interface wb_master_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
) ();

  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dat_w;
  logic              ack;
  logic [DATA_W-1:0] dat_r;

  modport master (
    output cyc, stb, we, addr, dat_w,
    input  ack, dat_r
  );

  modport slave (
    input  cyc, stb, we, addr, dat_w,
    output ack, dat_r
  );

endinterface : wb_master_arbiter_if

// File: rtl/wb_master_arbiter_watchdog.sv
// ---------------------------------------------------------------------------
// wb_arb_watchdog
// Stall counter for a granted Wishbone cycle. Counts consecutive cycles in
// which the arbiter is enabled and not cleared; flags expiry when the count
// equals TIMEOUT. Only instantiated when WB_ARB_WATCHDOG_EN is defined.
// Ports:
//   i_clk      : clock
//   i_rst      : synchronous active-high reset
//   i_clear    : strobe idle or acknowledged this cycle -> restart count
//   i_enable   : a master owns the bus; low forces the count to zero
//   o_expired  : count has reached TIMEOUT while enabled
// ---------------------------------------------------------------------------
module wb_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT);

  logic [15:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear || !i_enable) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 16'd1;
    end
  end

  // Expiry is decided on the registered count, so it fires in the cycle
  // after TIMEOUT stalled cycles have been seen.
  assign o_expired = i_enable && (r_count == LIMIT);

endmodule : wb_arb_watchdog

// File: rtl/wb_master_arbiter.sv
// ---------------------------------------------------------------------------
// wb_master_arbiter
// Round-robin arbiter giving the shared 24-bit/8-bit Wishbone bus to either
// the CPU core (master 0) or the UART debug bridge (master 1), one whole
// cyc at a time. Request/control/data are muxed to the slave by the
// registered grant state; ack and read data return only to the owner.
// Optional watchdog (define WB_ARB_WATCHDOG_EN) aborts a granted cycle whose
// strobe goes TIMEOUT cycles without ack and pulses the owner's err.
// Ports:
//   i_wb_clk  : clock
//   i_wb_rst  : synchronous active-high reset
//   m0_if     : CPU master link (slave modport)
//   m1_if     : debug-bridge master link (slave modport)
//   wb_if     : system bus towards the slaves (master modport)
//   o_m0_err  : abort pulse to master 0 (0 without the watchdog)
//   o_m1_err  : abort pulse to master 1 (0 without the watchdog)
//   o_grant   : one-hot owner, bit0 = master 0, bit1 = master 1, 00 = idle
// ---------------------------------------------------------------------------
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int DATA_W  = WB_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                       i_wb_clk,
  input  logic                       i_wb_rst,
  wb_master_arbiter_if.slave         m0_if,
  wb_master_arbiter_if.slave         m1_if,
  wb_master_arbiter_if.master        wb_if,
  output logic                       o_m0_err,
  output logic                       o_m1_err,
  output logic [1:0]                 o_grant
);

  arb_state_e r_state;
  arb_state_e w_next_state;
  logic       r_last;
  logic       w_abort;

  // NOTE: registered state is written with non-blocking assignments only,
  // so every reader sees the pre-edge value regardless of process order.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      r_state <= IDLE;
      r_last  <= M_DBG;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && w_next_state == GNT0) r_last <= M_CPU;
      if (r_state == IDLE && w_next_state == GNT1) r_last <= M_DBG;
    end
  end

  // Grants are only issued from IDLE, so a release always costs one idle
  // cycle before the next owner; on a tie the master not granted last wins.
  // NOTE: each combinational block assigns its outputs a default first, so
  // no path through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (m0_if.cyc && (!m1_if.cyc || r_last == M_DBG)) w_next_state = GNT0;
        else if (m1_if.cyc)                              w_next_state = GNT1;
      end
      GNT0:    if (!m0_if.cyc || w_abort) w_next_state = IDLE;
      GNT1:    if (!m1_if.cyc || w_abort) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Forward and return muxes, selected by the registered state only.
  always_comb begin
    wb_if.cyc   = 1'b0;
    wb_if.stb   = 1'b0;
    wb_if.we    = 1'b0;
    wb_if.addr  = {ADDR_W{1'b0}};
    wb_if.dat_w = {DATA_W{1'b0}};
    m0_if.ack   = 1'b0;
    m0_if.dat_r = {DATA_W{1'b0}};
    m1_if.ack   = 1'b0;
    m1_if.dat_r = {DATA_W{1'b0}};
    o_grant     = 2'b00;
    case (r_state)
      GNT0: begin
        wb_if.cyc   = m0_if.cyc;
        wb_if.stb   = m0_if.stb;
        wb_if.we    = m0_if.we;
        wb_if.addr  = m0_if.addr;
        wb_if.dat_w = m0_if.dat_w;
        m0_if.ack   = wb_if.ack;
        m0_if.dat_r = wb_if.dat_r;
        o_grant     = 2'b01;
      end
      GNT1: begin
        wb_if.cyc   = m1_if.cyc;
        wb_if.stb   = m1_if.stb;
        wb_if.we    = m1_if.we;
        wb_if.addr  = m1_if.addr;
        wb_if.dat_w = m1_if.dat_w;
        m1_if.ack   = wb_if.ack;
        m1_if.dat_r = wb_if.dat_r;
        o_grant     = 2'b10;
      end
      default: ;  // IDLE: bus parked, late acks are dropped
    endcase
  end

`ifdef WB_ARB_WATCHDOG_EN
  logic w_wd_expired;

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk     (i_wb_clk),
    .i_rst     (i_wb_rst),
    .i_clear   (!wb_if.stb || wb_if.ack),
    .i_enable  (r_state != IDLE),
    .o_expired (w_wd_expired)
  );

  // r_last already names the aborted master, so the other one wins next.
  assign w_abort  = w_wd_expired;
  assign o_m0_err = w_wd_expired && (r_state == GNT0);
  assign o_m1_err = w_wd_expired && (r_state == GNT1);
`else
  logic w_unused_timeout;

  assign w_unused_timeout = |TIMEOUT;
  assign w_abort          = 1'b0;
  assign o_m0_err         = 1'b0;
  assign o_m1_err         = 1'b0;
`endif

endmodule : wb_master_arbiter

// File: tb/tb_wb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_master_arbiter
// Self-checking bench for wb_master_arbiter. A transaction-level model
// (current owner, last owner, stall length) predicts every output each
// cycle; directed scenarios add explicit checks, then a randomized phase
// runs against the same model. Build with WB_ARB_WATCHDOG_EN to include the
// watchdog scenario (TIMEOUT = 4).
// ---------------------------------------------------------------------------
module tb_wb_master_arbiter;
  import wb_arb_pkg::*;

  localparam int AW = 24;
  localparam int DW = 8;
`ifdef WB_ARB_WATCHDOG_EN
  localparam int TMO = 4;
  localparam bit WD  = 1'b1;
`else
  localparam int TMO = 255;
  localparam bit WD  = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       m0_err;
  logic       m1_err;
  logic [1:0] grant;

  wb_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
  wb_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();
  wb_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) wb_bus ();

  wb_master_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TMO)
  ) dut (
    .i_wb_clk (clk),
    .i_wb_rst (rst),
    .m0_if    (m0_bus),
    .m1_if    (m1_bus),
    .wb_if    (wb_bus),
    .o_m0_err (m0_err),
    .o_m1_err (m1_err),
    .o_grant  (grant)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, who owned it last, stall length.
  int owner = -1;
  int last  = 1;
  int stall = 0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_m0(input bit c, input bit s, input bit w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    m0_bus.cyc = c; m0_bus.stb = s; m0_bus.we = w; m0_bus.addr = a; m0_bus.dat_w = d;
  endtask

  task automatic set_m1(input bit c, input bit s, input bit w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    m1_bus.cyc = c; m1_bus.stb = s; m1_bus.we = w; m1_bus.addr = a; m1_bus.dat_w = d;
  endtask

  // Compare every DUT output against what the model says the bus looks like.
  task automatic check_outputs();
    logic          e_cyc, e_stb, e_we, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_dat;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_addr = '0; e_dat = '0;
    if (owner == 0) begin
      e_cyc = m0_bus.cyc; e_stb = m0_bus.stb; e_we = m0_bus.we;
      e_addr = m0_bus.addr; e_dat = m0_bus.dat_w;
    end else if (owner == 1) begin
      e_cyc = m1_bus.cyc; e_stb = m1_bus.stb; e_we = m1_bus.we;
      e_addr = m1_bus.addr; e_dat = m1_bus.dat_w;
    end
    e_err = WD && (owner >= 0) && (stall == TMO);
    check("grant",  grant,        owner == 0 ? 2'b01 : (owner == 1 ? 2'b10 : 2'b00));
    check("wb_cyc", wb_bus.cyc,   e_cyc);
    check("wb_stb", wb_bus.stb,   e_stb);
    check("wb_we",  wb_bus.we,    e_we);
    check("wb_adr", wb_bus.addr,  e_addr);
    check("wb_dat", wb_bus.dat_w, e_dat);
    check("m0_ack", m0_bus.ack,   (owner == 0) && wb_bus.ack);
    check("m0_dat", m0_bus.dat_r, owner == 0 ? wb_bus.dat_r : 8'h00);
    check("m0_err", m0_err,       e_err && owner == 0);
    check("m1_ack", m1_bus.ack,   (owner == 1) && wb_bus.ack);
    check("m1_dat", m1_bus.dat_r, owner == 1 ? wb_bus.dat_r : 8'h00);
    check("m1_err", m1_err,       e_err && owner == 1);
  endtask

  // Advance the model across one clock edge using the inputs held there.
  task automatic model_step();
    bit oc, os, abort;
    if (rst) begin
      owner = -1; last = 1; stall = 0;
    end else if (owner < 0) begin
      if (m0_bus.cyc && m1_bus.cyc) owner = 1 - last;
      else if (m0_bus.cyc)          owner = 0;
      else if (m1_bus.cyc)          owner = 1;
      if (owner >= 0) last = owner;
      stall = 0;
    end else begin
      oc    = (owner == 0) ? m0_bus.cyc : m1_bus.cyc;
      os    = (owner == 0) ? m0_bus.stb : m1_bus.stb;
      abort = WD && (stall == TMO);
      stall = (os && !wb_bus.ack) ? stall + 1 : 0;
      if (!oc || abort) begin
        owner = -1;
        stall = 0;
      end
    end
  endtask

  // One bus cycle: check outputs mid-cycle, cross the edge, update model.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    logic [1:0] glog[$];
    wr_t        slog[$];
    bit         ack0_prev, ack1_prev, e0, e1;
    int         ng, idle_run, len0, len1;
    logic [1:0] prev;

    // ---------------- reset ----------------
    rst = 1'b1;
    set_m0(0, 0, 0, '0, '0);
    set_m1(0, 0, 0, '0, '0);
    wb_bus.ack = 1'b0; wb_bus.dat_r = '0;
    @(posedge clk); #1;
    cycle();
    check("rst_grant",  grant, 2'b00);
    check("rst_wb_cyc", wb_bus.cyc, 1'b0);
    check("rst_err",    {m0_err, m1_err}, 2'b00);
    rst = 1'b0;
    cycle();

    // ---------------- single master: m1 read ----------------
    set_m1(1, 1, 0, 24'h000010, 8'h00);
    cycle();
    check("t1_grant", grant, 2'b10);
    check("t1_addr",  wb_bus.addr, 24'h000010);
    cycle();
    cycle();
    wb_bus.ack = 1'b1; wb_bus.dat_r = 8'h5A; #1;
    check("t1_m1_dat", m1_bus.dat_r, 8'h5A);
    check("t1_m1_ack", m1_bus.ack, 1'b1);
    check("t1_m0_ack", m0_bus.ack, 1'b0);
    cycle();
    wb_bus.ack = 1'b0; wb_bus.dat_r = '0;
    set_m1(0, 0, 0, '0, '0);
    cycle();
    // late ack while idle must reach nobody
    wb_bus.ack = 1'b1; wb_bus.dat_r = 8'hC3; #1;
    check("late_m0_ack", m0_bus.ack, 1'b0);
    check("late_m1_ack", m1_bus.ack, 1'b0);
    check("late_m1_dat", m1_bus.dat_r, 8'h00);
    cycle();
    wb_bus.ack = 1'b0; wb_bus.dat_r = '0;

    // ---------------- tie after reset ----------------
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set_m0(1, 1, 0, 24'h000020, 8'h00);
    set_m1(1, 1, 0, 24'h000030, 8'h00);
    cycle();
    check("t2_first_m0", grant, 2'b01);
    wb_bus.ack = 1'b1;
    cycle();
    wb_bus.ack = 1'b0;
    set_m0(0, 0, 0, '0, '0);
    cycle();
    check("t2_idle", grant, 2'b00);
    cycle();
    check("t2_then_m1", grant, 2'b10);
    wb_bus.ack = 1'b1;
    cycle();
    wb_bus.ack = 1'b0;
    set_m1(0, 0, 0, '0, '0);
    cycle();
    cycle();

    // ---------------- fairness ----------------
    set_m0(1, 1, 0, 24'h000200, 8'h00);
    set_m1(1, 1, 0, 24'h000300, 8'h00);
    ack0_prev = 1'b0; ack1_prev = 1'b0;
    for (int c = 0; c < 40; c++) begin
      m0_bus.cyc = !ack0_prev; m0_bus.stb = !ack0_prev;
      m1_bus.cyc = !ack1_prev; m1_bus.stb = !ack1_prev;
      #1;
      wb_bus.ack   = wb_bus.stb;
      wb_bus.dat_r = 8'($urandom);
      #1;
      glog.push_back(grant);
      ack0_prev = m0_bus.ack;
      ack1_prev = m1_bus.ack;
      cycle();
    end
    ng = 0; idle_run = 0; prev = 2'b00;
    foreach (glog[i]) begin
      if (glog[i] == 2'b00) begin
        idle_run++;
      end else if (glog[i] != prev) begin
        if (ng > 0 && ng < 8) check("fair_gap", idle_run, 1);
        if (ng < 8) check("fair_seq", glog[i], (ng % 2 == 0) ? 2'b01 : 2'b10);
        ng++;
        idle_run = 0;
      end
      prev = glog[i];
    end
    check("fair_count", ng >= 8, 1'b1);
    set_m0(0, 0, 0, '0, '0);
    set_m1(0, 0, 0, '0, '0);
    wb_bus.ack = 1'b0;
    cycle();
    cycle();
    cycle();

    // ---------------- locking ----------------
    set_m1(1, 0, 1, 24'h000100, 8'h11);
    cycle();
    check("t4_grant", grant, 2'b10);
    set_m0(1, 1, 0, 24'h000400, 8'h00);
    for (int k = 0; k < 3; k++) begin
      m1_bus.stb = 1'b1; m1_bus.we = 1'b1;
      m1_bus.addr  = 24'h000100 + 24'(k);
      m1_bus.dat_w = 8'(8'h11 * (k + 1));
      #1;
      wb_bus.ack = 1'b1;
      #1;
      if (wb_bus.cyc && wb_bus.stb && wb_bus.we && wb_bus.ack)
        slog.push_back('{a: wb_bus.addr, d: wb_bus.dat_w});
      check("t4_hold", grant, 2'b10);
      cycle();
      wb_bus.ack = 1'b0;
      m1_bus.stb = 1'b0;
      cycle();
    end
    m1_bus.cyc = 1'b0;
    cycle();
    check("t4_release", grant, 2'b00);
    cycle();
    check("t4_m0_after", grant, 2'b01);
    check("t4_nwr", slog.size(), 3);
    for (int k = 0; k < 3 && k < slog.size(); k++) begin
      check("t4_wr_addr", slog[k].a, 24'h000100 + 24'(k));
      check("t4_wr_dat",  slog[k].d, 8'(8'h11 * (k + 1)));
    end

    // ---------------- reset mid-cycle ----------------
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t5_wb_cyc", wb_bus.cyc, 1'b0);
    check("t5_grant",  grant, 2'b00);
    check("t5_m0_ack", m0_bus.ack, 1'b0);
    check("t5_m0_err", m0_err, 1'b0);
    set_m0(0, 0, 0, '0, '0);
    set_m1(1, 1, 0, 24'h000040, 8'h00);
    cycle();
    check("t5_m1_grant", grant, 2'b10);
    wb_bus.ack = 1'b1;
    cycle();
    wb_bus.ack = 1'b0;
    set_m1(0, 0, 0, '0, '0);
    cycle();
    cycle();

`ifdef WB_ARB_WATCHDOG_EN
    // ---------------- watchdog ----------------
    begin : wd_test
      int n_err, err_at, m1_at;
      bit e;
      n_err = 0; err_at = -1; m1_at = -1;
      set_m0(1, 1, 0, 24'h000050, 8'h00);
      cycle();
      set_m1(1, 1, 0, 24'h000060, 8'h00);
      for (int c = 0; c < 9; c++) begin
        #1;
        e = m0_err;
        if (e) begin
          n_err++;
          if (err_at < 0) err_at = c;
        end
        if (grant == 2'b10 && m1_at < 0) m1_at = c;
        cycle();
        if (e) set_m0(0, 0, 0, '0, '0);
      end
      check("wd_err_pulses", n_err, 1);
      check("wd_err_cycle",  err_at, 4);
      check("wd_m1_next",    m1_at, 6);
      wb_bus.ack = 1'b1;
      cycle();
      wb_bus.ack = 1'b0;
      set_m1(0, 0, 0, '0, '0);
      cycle();
      cycle();
    end
`endif

    // ---------------- randomized traffic ----------------
    len0 = 0; len1 = 0; e0 = 1'b0; e1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!m0_bus.cyc) begin
        if ($urandom_range(0, 2) == 0) begin
          set_m0(1, 1, 1'($urandom), 24'($urandom), 8'($urandom));
          len0 = $urandom_range(1, 6);
        end
      end else if (e0 || len0 == 0) begin
        set_m0(0, 0, 0, '0, '0);
      end else begin
        len0--;
        m0_bus.stb = 1'($urandom); m0_bus.addr = 24'($urandom); m0_bus.dat_w = 8'($urandom);
      end
      if (!m1_bus.cyc) begin
        if ($urandom_range(0, 2) == 0) begin
          set_m1(1, 1, 1'($urandom), 24'($urandom), 8'($urandom));
          len1 = $urandom_range(1, 6);
        end
      end else if (e1 || len1 == 0) begin
        set_m1(0, 0, 0, '0, '0);
      end else begin
        len1--;
        m1_bus.stb = 1'($urandom); m1_bus.addr = 24'($urandom); m1_bus.dat_w = 8'($urandom);
      end
      wb_bus.ack   = 1'($urandom);
      wb_bus.dat_r = 8'($urandom);
      #1;
      e0 = m0_err;
      e1 = m1_err;
      cycle();
    end
    rst = 1'b0;
    set_m0(0, 0, 0, '0, '0);
    set_m1(0, 0, 0, '0, '0);
    wb_bus.ack = 1'b0;
    cycle();
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_wb_master_arbiter
